// File: rtl/prog_loader_if.sv
// Host-word stream plus instruction-memory write port shared by the loader and its host.
interface prog_loader_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] instruct;

    modport master (
        output in_valid, in_data,
        input  in_ready, memWrite, adr, instruct
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, memWrite, adr, instruct
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a header-prefixed instruction image into memory, holding the core in reset until done.
// Optional trailing checksum word when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpuReset,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StData,
        StDone,
        StErr
`ifdef LOADER_CHECKSUM_EN
        , StCheck
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] instruct_q, instruct_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    logic accept;
    logic start_ok;
    logic hdr_bad;
    logic in_session_d;

    assign accept   = bus.in_valid && in_ready_q;
    assign start_ok = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    // Shift keeps this legal when DATA_WIDTH == ADDR_WIDTH (no upper bits at all).
    assign hdr_bad  = (bus.in_data >> ADDR_WIDTH) != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= '0;
            ptr_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            adr_q       <= '0;
            instruct_q  <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            ptr_q       <= ptr_d;
            in_ready_q  <= in_ready_d;
            mem_write_q <= mem_write_d;
            adr_q       <= adr_d;
            instruct_q  <= instruct_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StHeader;
            end
            StHeader: begin
                if (accept) state_d = hdr_bad ? StErr : StData;
            end
            StData: begin
                if (accept && ptr_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) state_d = (bus.in_data == sum_q) ? StDone : StErr;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        ptr_d       = ptr_q;
        mem_write_d = 1'b0;
        adr_d       = adr_q;
        instruct_d  = instruct_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        if (start_ok) sum_d = '0;
`endif
        if (state_q == StHeader && accept) begin
            last_d = bus.in_data[ADDR_WIDTH-1:0];
            ptr_d  = '0;
        end
        if (state_q == StData && accept) begin
            mem_write_d = 1'b1;
            adr_d       = ptr_q;
            instruct_d  = bus.in_data;
            ptr_d       = ptr_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_d       = sum_q + bus.in_data;
`endif
        end

        in_session_d = (state_d == StHeader) || (state_d == StData);
`ifdef LOADER_CHECKSUM_EN
        in_session_d = in_session_d || (state_d == StCheck);
`endif
        in_ready_d  = in_session_d;
        // Done lags DONE entry by a cycle so it follows the final write pulse.
        done_d      = (state_q == StDone) && (state_d == StDone);
        busy_d      = in_session_d || (state_q != StDone && state_d == StDone);
        error_d     = (state_d == StErr);
        cpu_reset_d = !done_d;
    end

    assign bus.in_ready = in_ready_q;
    assign bus.memWrite = mem_write_q;
    assign bus.adr      = adr_q;
    assign bus.instruct = instruct_q;
    assign cpuReset     = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes queued on word acceptance.
module tb_prog_loader;

    localparam int unsigned DW = 10;
    localparam int unsigned AW = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpuReset, busy, done, error;

    prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpuReset (cpuReset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  n_wr = 0;
    wr_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.memWrite === 1'b1) begin
            wr_t e;
            n_wr++;
            check_eq("done_during_wr", 32'(done), 32'd0);
            check_eq("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("wr_adr", 32'(bus.adr), 32'(e.a));
                check_eq("wr_data", 32'(bus.instruct), 32'(e.d));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was taken.
    task automatic send_word(input logic [DW-1:0] w, output bit ok);
        bit rdy;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < 100; i++) begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("accept", 32'(ok), 32'd1);
        if (!ok) bus.in_valid = 1'b0;
    endtask

    task automatic send_data(input logic [AW-1:0] a, input logic [DW-1:0] w);
        bit ok;
        send_word(w, ok);
        if (ok) sb.push_back('{a: a, d: w});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_data = DW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_check();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("done_lag", 32'(done), 32'd0);
        check_eq("cpurst_lag", 32'(cpuReset), 32'd1);
        @(negedge clk);
        check_eq("done", 32'(done), 32'd1);
        check_eq("cpurst_rel", 32'(cpuReset), 32'd0);
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("rdy_done", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        logic [DW-1:0] sum;
        logic [DW-1:0] w3[3];
        int            wr_base;
        w3[0] = 10'h3A1;
        w3[1] = 10'h0F0;
        w3[2] = 10'h155;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("idle_cpurst", 32'(cpuReset), 32'd1);
            check_eq("idle_wr", 32'(bus.memWrite), 32'd0);
            check_eq("idle_rdy", 32'(bus.in_ready), 32'd0);
            check_eq("idle_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;

        // Three-word image, back to back.
        pulse_start();
        send_word(10'h002, ok);
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            send_data(AW'(i), w3[i]);
            sum = sum + w3[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum, ok);
`endif
        finish_check();
        check_eq("wr_cnt3", 32'(n_wr), 32'd3);

        // Full 256-word image with random valid gaps, reloaded from DONE.
        wr_base = n_wr;
        pulse_start();
        send_word(10'h0FF, ok);
        sum = '0;
        for (int i = 0; i < 256; i++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            idle_gap(int'($urandom_range(0, 2)));
            send_data(AW'(i), w);
            sum = sum + w;
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum, ok);
`endif
        finish_check();
        check_eq("wr_cnt256", 32'(n_wr - wr_base), 32'd256);

        // Oversized header.
        wr_base = n_wr;
        pulse_start();
        send_word(10'h100, ok);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("hdr_err", 32'(error), 32'd1);
        check_eq("hdr_cpurst", 32'(cpuReset), 32'd1);
        check_eq("hdr_rdy", 32'(bus.in_ready), 32'd0);
        check_eq("hdr_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        check_eq("reload_err", 32'(error), 32'd0);
        check_eq("reload_rdy", 32'(bus.in_ready), 32'd1);
        check_eq("reload_busy", 32'(busy), 32'd1);
        check_eq("hdr_nowr", 32'(n_wr - wr_base), 32'd0);
        @(posedge clk);
        #1;

        // Four-word image aborted by reset after the second word; stray start ignored.
        wr_base = n_wr;
        send_word(10'h003, ok);
        send_data(8'd0, 10'h011);
        idle_gap(1);
        pulse_start();
        @(negedge clk);
        check_eq("start_ign_busy", 32'(busy), 32'd1);
        check_eq("start_ign_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send_data(8'd1, 10'h022);
        bus.in_data = 10'h3FF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_rdy", 32'(bus.in_ready), 32'd0);
        check_eq("abort_cpurst", 32'(cpuReset), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_wrcnt", 32'(n_wr - wr_base), 32'd2);
        @(posedge clk);
        #1;

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        send_word(10'h001, ok);
        send_data(8'd0, 10'h200);
        send_data(8'd1, 10'h300);
        send_word(10'h100, ok);
        finish_check();

        pulse_start();
        send_word(10'h001, ok);
        send_data(8'd0, 10'h200);
        send_data(8'd1, 10'h300);
        send_word(10'h101, ok);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("cks_err", 32'(error), 32'd1);
        check_eq("cks_cpurst", 32'(cpuReset), 32'd1);
        check_eq("cks_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
`endif

        repeat (2) @(posedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side program writer for the HMMM-style processor core; the write end of the instruction-memory interface the core fetches from.
- Accepts a header word plus a stream of instruction words over a valid/ready handshake.
- Writes each instruction word to consecutive memory addresses using memWrite/adr/instruct, the same signal names and widths as the processor top.
- Holds the core in reset until the image is fully loaded, then releases it.

Parameters:
DATA_WIDTH, 10, instruction word width; equals the instruct bus width. Must be >= ADDR_WIDTH.
ADDR_WIDTH, 8, memory address width; equals the adr bus width.

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session
in_valid  in  1  host word valid
in_data  in  DATA_WIDTH  host word (header or instruction)
in_ready  out  1  loader accepts in_data this cycle
memWrite  out  1  instruction-memory write strobe, one cycle per word
adr  out  ADDR_WIDTH  write address
instruct  out  DATA_WIDTH  write data
cpuReset  out  1  reset to processor core
busy  out  1  load session in progress
done  out  1  image loaded, core running
error  out  1  load failed

Behaviour:
- Reset, applied at the next posedge: memWrite=0, adr=0, instruct=0, cpuReset=1, busy=0, done=0, error=0, in_ready=0, state=IDLE.
- Reset mid-load aborts the session at the next posedge. No further memWrite pulses occur.
- Transfer rule: a word transfers only on a posedge with in_valid && in_ready. in_valid without in_ready is ignored, and in_data may change freely while in_valid=0.
- All outputs are registered.
- States:
  - IDLE: cpuReset=1, in_ready=0. start -> HEADER.
  - HEADER: busy=1, in_ready=1. Accepted word: last <= in_data[ADDR_WIDTH-1:0], ptr <= 0, then -> DATA. Nonzero in_data[DATA_WIDTH-1:ADDR_WIDTH] -> ERR.
  - DATA: busy=1, in_ready=1. Accepted word: next cycle memWrite=1, adr=ptr, instruct=in_data; ptr <= ptr+1. If ptr==last on acceptance -> DONE (or CHECK when the optional feature is enabled). Sustains one word per cycle.
  - DONE: busy=0, done=1, cpuReset=0, in_ready=0.
  - ERR: error=1, cpuReset=1, busy=0, in_ready=0.
- memWrite outside a write cycle is 0. adr and instruct hold their last values when memWrite=0.
- Word count is last+1, range 1..2^ADDR_WIDTH. last=255 writes adr 0..255; ptr wrap after the final word is irrelevant because the state changes.
- cpuReset deasserts in the same cycle done asserts, which is the cycle after the final memWrite pulse.
- start:
  - Honoured only in IDLE, DONE or ERR; ignored in HEADER/DATA/CHECK.
  - In DONE/ERR, start -> HEADER with cpuReset=1, done=0, error=0 on the next cycle (reload).
- start and in_valid in the same IDLE cycle: only start acts, because in_ready=0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: adds a CHECK state after DATA.
  - Running sum = mod-2^DATA_WIDTH sum of all instruction words, cleared on HEADER entry.
  - CHECK: in_ready=1. One accepted word is compared to the sum; match -> DONE, mismatch -> ERR.
  - Memory writes already performed are not undone.
- Undefined: no CHECK state, no sum register. DATA goes directly to DONE.

Test Plan:
- Reset, then idle 5 cycles -> cpuReset=1, memWrite=0, in_ready=0, done=0 throughout.
- start; header 0x002; words 0x3A1, 0x0F0, 0x155 back-to-back -> memWrite pulses at adr 0,1,2 with those data on consecutive cycles; done=1 and cpuReset=0 the cycle after the third pulse.
- Header 0x0FF and 256 words with in_valid toggling randomly -> exactly 256 pulses at adr 0..255 in order, none while in_valid=0, done only after adr 255.
- Header 0x100 (upper bits nonzero) -> ERR: error=1, cpuReset=1, no memWrite. A following start clears error and re-enters HEADER.
- Reset asserted after the 2nd of 4 words -> no further memWrite pulses, state IDLE, cpuReset=1. Extra start pulses during DATA are ignored.
- LOADER_CHECKSUM_EN: words 0x200, 0x300, checksum 0x100 -> done=1. Checksum 0x101 -> error=1, cpuReset stays 1.
